// File: rtl/grand_decode_ctrl.sv
// GRAND hard-decision search scheduler: walks error patterns in weight order against the codebook.
// Optional build macro GRAND_ABANDON_EN caps the search at MAX_QUERIES queries.
module grand_decode_ctrl #(
    parameter int WIDTH       = 8,
    parameter int MAX_QUERIES = 2**WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [0:WIDTH-1]               chat,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [0:WIDTH-1]               c_out,
    output logic                           found,
    output logic [$clog2(2**WIDTH+1)-1:0]  query_count,
    output logic                           busy
);
    localparam int QW = $clog2(2**WIDTH+1);
`ifdef GRAND_ABANDON_EN
    localparam int LIMIT = MAX_QUERIES;
`else
    localparam int LIMIT = 2**WIDTH;
`endif
    localparam logic [QW-1:0] LIMIT_Q = QW'(LIMIT);

    if (WIDTH != 7 && WIDTH != 8) begin : g_bad_width
        $error("grand_decode_ctrl: WIDTH must be 7 or 8");
    end
    if (MAX_QUERIES < 1 || MAX_QUERIES > 2**WIDTH) begin : g_bad_limit
        $error("grand_decode_ctrl: MAX_QUERIES out of range 1..2**WIDTH");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic [0:WIDTH-1]  chat_reg, chat_next;
    logic [0:WIDTH-1]  w_reg, w_next;
    logic [QW-1:0]     qcnt_reg, qcnt_next, qcnt_inc;
    logic              in_ready_reg, in_ready_next;
    logic              out_valid_reg, out_valid_next;
    logic [0:WIDTH-1]  c_out_reg, c_out_next;
    logic              found_reg, found_next;
    logic [QW-1:0]     query_count_reg, query_count_next;
    logic              busy_reg, busy_next;
    logic [0:WIDTH-1]  cand;
    logic              cmc_match;

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_cand
        assign cand[gi] = w_reg[gi] ^ chat_reg[gi];
    end

    // Codebook membership: data in bits 0..3, parity in the remaining bits.
    if (WIDTH == 8) begin : g_cmc8
        assign cmc_match = (cand[4] == (cand[1] ^ cand[2] ^ cand[3])) &&
                           (cand[5] == (cand[0] ^ cand[1] ^ cand[3])) &&
                           (cand[6] == (cand[0] ^ cand[2] ^ cand[3])) &&
                           (cand[7] == (cand[0] ^ cand[1] ^ cand[2]));
    end else begin : g_cmc7
        assign cmc_match = (cand[4] == (cand[0] ^ cand[1] ^ cand[2])) &&
                           (cand[5] == (cand[0] ^ cand[2] ^ cand[3])) &&
                           (cand[6] == (cand[1] ^ cand[2] ^ cand[3]));
    end

    // Next error pattern: within a weight, step to the next-smaller value (index 0 is MSB);
    // once the ones are packed at the right end, jump to the left-packed pattern of the next weight.
    function automatic logic [0:WIDTH-1] nep_next(input logic [0:WIDTH-1] pat);
        logic [0:WIDTH-1] nxt;
        int piv, tail, ones;
        piv  = -1;
        tail = 0;
        ones = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (pat[i] && !pat[i+1]) piv = i;
        end
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(pat[i]);
            if (i > piv + 1) tail = tail + int'(pat[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (piv < 0)               nxt[i] = (i <= ones);
            else if (i == piv)         nxt[i] = 1'b0;
            else if (i == piv + 1)     nxt[i] = 1'b1;
            else if (i > piv + 1)      nxt[i] = (i <= piv + 1 + tail);
            else                       nxt[i] = pat[i];
        end
        return nxt;
    endfunction

    assign qcnt_inc = qcnt_reg + QW'(1);

    always_comb begin
        state_next       = state_reg;
        chat_next        = chat_reg;
        w_next           = w_reg;
        qcnt_next        = qcnt_reg;
        in_ready_next    = in_ready_reg;
        out_valid_next   = out_valid_reg;
        c_out_next       = c_out_reg;
        found_next       = found_reg;
        query_count_next = query_count_reg;
        busy_next        = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready_reg) begin
                    chat_next     = chat;
                    w_next        = '0;
                    qcnt_next     = '0;
                    in_ready_next = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                qcnt_next = qcnt_inc;
                if (cmc_match) begin
                    c_out_next       = cand;
                    found_next       = 1'b1;
                    query_count_next = qcnt_inc;
                    out_valid_next   = 1'b1;
                    busy_next        = 1'b0;
                    state_next       = ST_DONE;
                end else if (qcnt_inc == LIMIT_Q) begin
                    c_out_next       = chat_reg;
                    found_next       = 1'b0;
                    query_count_next = LIMIT_Q;
                    out_valid_next   = 1'b1;
                    busy_next        = 1'b0;
                    state_next       = ST_DONE;
                end else begin
                    w_next = nep_next(w_reg);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            chat_reg        <= '0;
            w_reg           <= '0;
            qcnt_reg        <= '0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            c_out_reg       <= '0;
            found_reg       <= 1'b0;
            query_count_reg <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            chat_reg        <= chat_next;
            w_reg           <= w_next;
            qcnt_reg        <= qcnt_next;
            in_ready_reg    <= in_ready_next;
            out_valid_reg   <= out_valid_next;
            c_out_reg       <= c_out_next;
            found_reg       <= found_next;
            query_count_reg <= query_count_next;
            busy_reg        <= busy_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign c_out       = c_out_reg;
    assign found       = found_reg;
    assign query_count = query_count_reg;
    assign busy        = busy_reg;
endmodule

// File: tb/tb_grand_decode_ctrl.sv
// Scoreboard bench for grand_decode_ctrl: a WIDTH=8 and a WIDTH=7 instance, checked against
// a pattern-list / codebook reference model built from the generator matrices.
`timescale 1ns/1ps
module tb_grand_decode_ctrl;
    localparam int MQ8 = 5;
`ifdef GRAND_ABANDON_EN
    localparam int LIM8 = MQ8;
`else
    localparam int LIM8 = 256;
`endif
    localparam int LIM7 = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic iv8, ir8, ov8, or8, f8, bz8;
    logic [7:0] ch8, c8;
    logic [8:0] qc8;
    logic iv7, ir7, ov7, or7, f7, bz7;
    logic [6:0] ch7, c7;
    logic [7:0] qc7;

    grand_decode_ctrl #(.WIDTH(8), .MAX_QUERIES(MQ8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .chat(ch8),
        .out_valid(ov8), .out_ready(or8), .c_out(c8), .found(f8),
        .query_count(qc8), .busy(bz8));
    grand_decode_ctrl #(.WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .chat(ch7),
        .out_valid(ov7), .out_ready(or7), .c_out(c7), .found(f7),
        .query_count(qc7), .busy(bz7));

    typedef struct {
        logic [7:0] c;
        logic       f;
        int         q;
    } exp_t;

    exp_t sb8[$];
    exp_t sb7[$];
    exp_t e8, e7, hold8, hold7;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit cw8[256];
    bit cw7[128];
    int pat8[$];
    int pat7[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] c, input logic f, input int q);
        exp_t e;
        e.c = c; e.f = f; e.q = q;
        return e;
    endfunction

    // Codebooks from generator rows; pattern lists by weight, then descending value.
    task automatic build();
        logic [7:0] g8[4];
        logic [6:0] g7[4];
        logic [7:0] x8;
        logic [6:0] x7;
        logic [7:0] v8;
        g8[0] = 8'b10000111; g8[1] = 8'b01001101; g8[2] = 8'b00101011; g8[3] = 8'b00011110;
        g7[0] = 7'b1000110;  g7[1] = 7'b0100101;  g7[2] = 7'b0010111;  g7[3] = 7'b0001011;
        for (int m = 0; m < 16; m++) begin
            x8 = '0; x7 = '0;
            for (int i = 0; i < 4; i++) begin
                if (m[3-i]) begin x8 = x8 ^ g8[i]; x7 = x7 ^ g7[i]; end
            end
            cw8[x8] = 1'b1;
            cw7[x7] = 1'b1;
        end
        for (int k = 0; k <= 8; k++)
            for (int v = 255; v >= 0; v--) begin
                v8 = 8'(v);
                if ($countones(v8) == k) pat8.push_back(v);
            end
        for (int k = 0; k <= 7; k++)
            for (int v = 127; v >= 0; v--) begin
                v8 = 8'(v);
                if ($countones(v8) == k) pat7.push_back(v);
            end
    endtask

    function automatic exp_t model(input int w, input logic [7:0] word);
        exp_t e;
        logic [7:0] cand;
        int lim;
        lim = (w == 8) ? LIM8 : LIM7;
        e = mk(word, 1'b0, lim);
        for (int k = 0; k < lim; k++) begin
            cand = 8'((w == 8) ? pat8[k] : pat7[k]) ^ word;
            if ((w == 8) ? cw8[cand] : cw7[cand[6:0]]) return mk(cand, 1'b1, k + 1);
        end
        return e;
    endfunction

    logic pend8 = 0, prev8 = 0, hs8 = 0;
    logic pend7 = 0, prev7 = 0, hs7 = 0;
    int acc8 = 0, acc7 = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend8 = 0; prev8 = 0; hs8 = 0;
        end else begin
            if (hs8) begin chk("ready_after_hs8", ir8, 1); chk("valid_drop8", ov8, 0); end
            if (ov8 && !prev8) begin
                if (sb8.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result8: got c_out=%b, want no result", c8);
                end else begin
                    e8 = sb8.pop_front();
                    $display("txn w8: c_out=%b found=%0d query_count=%0d", c8, f8, qc8);
                    chk("c_out8", c8, e8.c);
                    chk("found8", f8, e8.f);
                    chk("query_count8", qc8, e8.q);
                    chk("accepted8", pend8, 1);
                    chk("latency8", cyc - acc8, e8.q);
                end
                hold8 = mk(c8, f8, int'(qc8));
                pend8 = 0;
            end else if (ov8) begin
                chk("hold_c_out8", c8, hold8.c);
                chk("hold_found8", f8, hold8.f);
                chk("hold_qc8", qc8, hold8.q);
            end
            if (ov8) chk("ready_low_done8", ir8, 0);
            if (iv8 && ir8) begin acc8 = cyc + 1; pend8 = 1; end
            hs8 = ov8 && or8;
            prev8 = ov8 && !or8;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend7 = 0; prev7 = 0; hs7 = 0;
        end else begin
            if (hs7) begin chk("ready_after_hs7", ir7, 1); chk("valid_drop7", ov7, 0); end
            if (ov7 && !prev7) begin
                if (sb7.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result7: got c_out=%b, want no result", c7);
                end else begin
                    e7 = sb7.pop_front();
                    $display("txn w7: c_out=%b found=%0d query_count=%0d", c7, f7, qc7);
                    chk("c_out7", {1'b0, c7}, e7.c);
                    chk("found7", f7, e7.f);
                    chk("query_count7", qc7, e7.q);
                    chk("accepted7", pend7, 1);
                    chk("latency7", cyc - acc7, e7.q);
                end
                hold7 = mk({1'b0, c7}, f7, int'(qc7));
                pend7 = 0;
            end else if (ov7) begin
                chk("hold_c_out7", {1'b0, c7}, hold7.c);
                chk("hold_qc7", qc7, hold7.q);
            end
            if (ov7) chk("ready_low_done7", ir7, 0);
            if (iv7 && ir7) begin acc7 = cyc + 1; pend7 = 1; end
            hs7 = ov7 && or7;
            prev7 = ov7 && !or7;
        end
    end

    task automatic issue8(input logic [7:0] word, input exp_t e, input int bp);
        int n;
        sb8.push_back(e);
        n = 0;
        while (!ir8 && n < 500) begin @(posedge clk); #1; n++; end
        if (!ir8) begin n_cmp++; n_bad++; $display("FAIL accept_timeout8: got in_ready=0, want 1"); end
        iv8 = 1'b1; ch8 = word;
        @(posedge clk); #1;
        iv8 = 1'b0;
        or8 = (bp == 0);
        n = 0;
        while (!ov8 && n < 500) begin @(posedge clk); #1; n++; end
        if (!ov8) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout8: got out_valid=0, want 1");
            sb8.delete();
        end
        if (bp > 0) begin
            iv8 = 1'b1; ch8 = ~word;
            repeat (bp) begin @(posedge clk); #1; end
            iv8 = 1'b0; or8 = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic issue7(input logic [6:0] word, input exp_t e, input int bp);
        int n;
        sb7.push_back(e);
        n = 0;
        while (!ir7 && n < 500) begin @(posedge clk); #1; n++; end
        if (!ir7) begin n_cmp++; n_bad++; $display("FAIL accept_timeout7: got in_ready=0, want 1"); end
        iv7 = 1'b1; ch7 = word;
        @(posedge clk); #1;
        iv7 = 1'b0;
        or7 = (bp == 0);
        n = 0;
        while (!ov7 && n < 500) begin @(posedge clk); #1; n++; end
        if (!ov7) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout7: got out_valid=0, want 1");
            sb7.delete();
        end
        if (bp > 0) begin
            iv7 = 1'b1; ch7 = ~word;
            repeat (bp) begin @(posedge clk); #1; end
            iv7 = 1'b0; or7 = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        int bp;
        rst = 1'b1;
        iv8 = 1'b0; ch8 = '0; or8 = 1'b1;
        iv7 = 1'b0; ch7 = '0; or7 = 1'b1;
        build();
        repeat (2) @(posedge clk);
        #1;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("rst_in_ready8", ir8, 1);
        chk("rst_out_valid8", ov8, 0);
        chk("rst_c_out8", c8, 0);
        chk("rst_found8", f8, 0);
        chk("rst_qc8", qc8, 0);
        chk("rst_busy8", bz8, 0);
        chk("rst_in_ready7", ir7, 1);
        chk("rst_out_valid7", ov7, 0);
        rst = 1'b0;

`ifdef GRAND_ABANDON_EN
        issue8(8'b00101011, mk(8'b00101011, 1'b1, 1), 0);
        issue8(8'b00101010, mk(8'b00101010, 1'b0, 5), 0);
        issue8(8'b11000000, mk(8'b11000000, 1'b0, 5), 3);
`else
        issue8(8'b00101011, mk(8'b00101011, 1'b1, 1), 0);
        issue8(8'b00101010, mk(8'b00101011, 1'b1, 9), 0);
        issue8(8'b11000000, mk(8'b00000000, 1'b1, 10), 3);
`endif
        for (int t = 0; t < 40; t++) begin
            w = 8'($urandom_range(0, 255));
            bp = $urandom_range(0, 2);
            issue8(w, model(8, w), bp);
        end

        // Reset during SEARCH: no result may follow.
        iv8 = 1'b1; ch8 = 8'b11000000;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("busy_search8", bz8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready8", ir8, 1);
        chk("midrst_out_valid8", ov8, 0);
        chk("midrst_busy8", bz8, 0);
        repeat (20) begin @(posedge clk); #1; end

        issue7(7'b0001010, mk(8'b00001011, 1'b1, 8), 0);
        issue7(7'b0001011, mk(8'b00001011, 1'b1, 1), 2);
        for (int t = 0; t < 20; t++) begin
            w = 8'($urandom_range(0, 127));
            bp = $urandom_range(0, 2);
            issue7(w[6:0], model(7, w), bp);
        end

        repeat (5) begin @(posedge clk); #1; end
        chk("sb8_drained", sb8.size(), 0);
        chk("sb7_drained", sb7.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
